// File: rtl/riscv_core_hazard_unit.sv
// Pipeline hazard unit for a 5-stage RISC-V core.
// Purpose: EX-stage operand forwarding, load-use bubble insertion, branch
// flushes, and stalling the front of the pipe while a multicycle MDU op runs
// (with a watchdog that aborts a hung MDU and latches a sticky error).
// Ports:
//   i_clk, i_rst_n              clock, async active-low reset
//   i_hzrd_rs*_d / rs*_e        decode / execute source registers
//   i_hzrd_rd_e, i_hzrd_load_e  execute destination, execute is a load
//   i_hzrd_rd_m/_w, regwrite    memory / writeback destination + write enable
//   i_hzrd_pcsrc_e              taken branch/jump resolved in execute
//   i_hzrd_mdu_start_e/_done    MDU issue in execute / MDU result valid
//   o_hzrd_fwda_e/_fwdb_e       forward selects (00 RF, 01 WB, 10 MEM)
//   o_hzrd_stall_f/_d/_e        hold pipeline registers
//   o_hzrd_flush_d/_e/_m        clear pipeline registers
//   o_hzrd_mdu_err              sticky MDU timeout flag
module riscv_core_hazard_unit #(
  parameter int unsigned MDU_TIMEOUT = 64
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [4:0] i_hzrd_rs1_d,
  input  logic [4:0] i_hzrd_rs2_d,
  input  logic [4:0] i_hzrd_rs1_e,
  input  logic [4:0] i_hzrd_rs2_e,
  input  logic [4:0] i_hzrd_rd_e,
  input  logic       i_hzrd_load_e,
  input  logic [4:0] i_hzrd_rd_m,
  input  logic       i_hzrd_regwrite_m,
  input  logic [4:0] i_hzrd_rd_w,
  input  logic       i_hzrd_regwrite_w,
  input  logic       i_hzrd_pcsrc_e,
  input  logic       i_hzrd_mdu_start_e,
  input  logic       i_hzrd_mdu_done,
  output logic [1:0] o_hzrd_fwda_e,
  output logic [1:0] o_hzrd_fwdb_e,
  output logic       o_hzrd_stall_f,
  output logic       o_hzrd_stall_d,
  output logic       o_hzrd_stall_e,
  output logic       o_hzrd_flush_d,
  output logic       o_hzrd_flush_e,
  output logic       o_hzrd_flush_m,
  output logic       o_hzrd_mdu_err
);

  localparam int unsigned CW = $clog2(MDU_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MDU_TIMEOUT - 1);

  typedef enum logic {
    IDLE     = 1'b0,
    MDU_BUSY = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          lu;

  // Forward select for one EX operand; the memory stage holds the newer value.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (i_hzrd_regwrite_m && (i_hzrd_rd_m != 5'd0) && (i_hzrd_rd_m == rs))
      return 2'b10;
    else if (i_hzrd_regwrite_w && (i_hzrd_rd_w != 5'd0) && (i_hzrd_rd_w == rs))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  // Forwarding is purely combinational and independent of the FSM.
  always_comb begin
    o_hzrd_fwda_e = fwd_sel(i_hzrd_rs1_e);
    o_hzrd_fwdb_e = fwd_sel(i_hzrd_rs2_e);
  end

  // Load-use hazard is only meaningful while the pipe is not frozen by the MDU.
  assign lu = (state_q == IDLE) && i_hzrd_load_e && (i_hzrd_rd_e != 5'd0) &&
              ((i_hzrd_rd_e == i_hzrd_rs1_d) || (i_hzrd_rd_e == i_hzrd_rs2_d));

  // State, watchdog counter and sticky error register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Next state and stall/flush decode.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    err_d          = err_q;
    o_hzrd_stall_f = 1'b0;
    o_hzrd_stall_d = 1'b0;
    o_hzrd_stall_e = 1'b0;
    o_hzrd_flush_d = 1'b0;
    o_hzrd_flush_e = 1'b0;
    o_hzrd_flush_m = 1'b0;
    case (state_q)
      IDLE: begin
        // A taken branch discards the younger instructions, so it beats load-use.
        if (i_hzrd_pcsrc_e) begin
          o_hzrd_flush_d = 1'b1;
          o_hzrd_flush_e = 1'b1;
        end else if (lu) begin
          o_hzrd_stall_f = 1'b1;
          o_hzrd_stall_d = 1'b1;
          o_hzrd_flush_e = 1'b1;
        end
        // Single-cycle MDU results (done with start) never enter the busy state.
        if (i_hzrd_mdu_start_e && !i_hzrd_mdu_done) begin
          state_d = MDU_BUSY;
          cnt_d   = '0;
        end
      end
      MDU_BUSY: begin
        if (i_hzrd_mdu_done) begin
          state_d = IDLE;
        end else begin
          o_hzrd_stall_f = 1'b1;
          o_hzrd_stall_d = 1'b1;
          o_hzrd_stall_e = 1'b1;
          o_hzrd_flush_m = 1'b1;
          cnt_d          = cnt_q + CW'(1);
          // Watchdog: give up on a hung MDU after MDU_TIMEOUT stalled cycles.
          if (cnt_q == CNT_LAST) begin
            state_d = IDLE;
            err_d   = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_hzrd_mdu_err = err_q;

endmodule

// File: doc/riscv_core_hazard_unit.md
RISCV_CORE_HAZARD_UNIT -- requirements
Module: riscv_core_hazard_unit

Interface
REQ-001 The block SHALL take parameter MDU_TIMEOUT, default 64: maximum cycles in MDU_BUSY before abort.
REQ-002 The block SHALL use a single clock and an asynchronous, active-low reset; the ports are listed below.
- i_clk  in  1  rising-edge clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_hzrd_rs1_d, i_hzrd_rs2_d  in  5 each  decode-stage source registers.
- i_hzrd_rs1_e, i_hzrd_rs2_e  in  5 each  execute-stage source registers.
- i_hzrd_rd_e  in  5  execute-stage destination.
- i_hzrd_load_e  in  1  execute-stage instruction is a load.
- i_hzrd_rd_m  in  5  memory-stage destination.
- i_hzrd_regwrite_m  in  1  memory-stage instruction writes the register file.
- i_hzrd_rd_w  in  5  writeback-stage destination.
- i_hzrd_regwrite_w  in  1  writeback-stage instruction writes the register file.
- i_hzrd_pcsrc_e  in  1  taken branch or jump resolved in execute.
- i_hzrd_mdu_start_e  in  1  multicycle mul/div issued in execute.
- i_hzrd_mdu_done  in  1  MDU result valid.
- o_hzrd_fwda_e, o_hzrd_fwdb_e  out  2 each  forwarding-mux selects: 00 register file, 01 writeback result, 10 memory-stage result.
- o_hzrd_stall_f, o_hzrd_stall_d, o_hzrd_stall_e  out  1 each  hold the fetch, decode and execute pipeline registers.
- o_hzrd_flush_d, o_hzrd_flush_e, o_hzrd_flush_m  out  1 each  clear the decode, execute and memory pipeline registers.
- o_hzrd_mdu_err  out  1  sticky flag: MDU timeout occurred.

Function
REQ-003 fwdA SHALL be 10 when regwrite_m=1, rd_m!=0 and rd_m==rs1_e.
REQ-004 Otherwise fwdA SHALL be 01 when regwrite_w=1, rd_w!=0 and rd_w==rs1_e.
REQ-005 Otherwise fwdA SHALL be 00; fwdB SHALL follow REQ-003 to REQ-005 using rs2_e; the code 11 SHALL never be driven.
REQ-006 Forward selects SHALL be combinational and state-independent.
REQ-007 The FSM SHALL have the states IDLE and MDU_BUSY, hold a counter of clog2(MDU_TIMEOUT+1) bits, and be updated on the rising edge of i_clk.
REQ-008 Load-use hazard (lu) = IDLE & load_e & rd_e!=0 & (rd_e==rs1_d | rd_e==rs2_d).
REQ-009 In IDLE with lu=1 and pcsrc_e=0: stall_f=stall_d=1 and flush_e=1 for that cycle only, inserting one bubble.
REQ-010 In IDLE with pcsrc_e=1: flush_d=flush_e=1 and stall_f=stall_d=0, regardless of lu (the branch wins).
REQ-011 In IDLE with mdu_start_e=1 and mdu_done=0: next state MDU_BUSY, counter cleared to 0; no stall is asserted in the issue cycle.
REQ-012 In IDLE with mdu_start_e=1 and mdu_done=1 (single-cycle op): remain in IDLE with no stall.
REQ-013 In MDU_BUSY: stall_f=stall_d=stall_e=1 and flush_m=1; pcsrc_e and lu are ignored; the counter increments each cycle.
REQ-014 In MDU_BUSY with mdu_done=1: all stalls and flush_m deassert in the same cycle; next state IDLE.
REQ-015 In MDU_BUSY with the counter at MDU_TIMEOUT-1 and mdu_done=0: next state IDLE, mdu_err set to 1; stalls release in the following cycle.
REQ-016 mdu_err SHALL stay set until reset.
REQ-017 All outputs not named as asserted in a given state or condition SHALL be 0.

Reset
REQ-018 Asserting i_rst_n=0 SHALL immediately force state IDLE, counter 0 and mdu_err 0, regardless of the clock.
REQ-019 While in reset, the stall and flush outputs SHALL be 0 unless pcsrc_e or lu is asserted; the forward selects SHALL remain purely combinational.
REQ-020 Reset asserted in MDU_BUSY SHALL release all stalls immediately, with no residual bubble after deassertion.

Verification
REQ-021 Forwarding: rs1_e=5, rd_m=5, regwrite_m=1, rd_w=5, regwrite_w=1 -> fwdA=10; then regwrite_m=0 -> fwdA=01; then rd_w=0 -> fwdA=00.
REQ-022 Load-use: load_e=1, rd_e=7, rs2_d=7 -> stall_f=stall_d=flush_e=1 for exactly 1 cycle; rd_e=0 -> no stall.
REQ-023 Branch plus load-use: pcsrc_e=1 with lu=1 -> flush_d=flush_e=1, stall_f=0.
REQ-024 MDU: mdu_start_e pulse, then mdu_done after 10 cycles -> stall_e=flush_m=1 for 10 cycles, dropping in the done cycle; mdu_start_e with mdu_done together -> no stall.
REQ-025 Timeout: MDU_TIMEOUT=8, mdu_done never asserted -> stalls last 8 cycles, mdu_err=1 and stays 1; then i_rst_n pulse -> mdu_err=0.
REQ-026 Async reset: assert i_rst_n=0 between clock edges in cycle 3 of MDU_BUSY -> stalls drop without waiting for a clock edge; state is IDLE after reset release.
